// File: rtl/clawgame_pkg.sv
// Shared claw-game constants, FSM encodings and small helpers.
package clawgame_pkg;

    localparam int unsigned CLK_HZ                 = 100_000_000;
    localparam int unsigned SCORE_W                = 16;

    localparam int unsigned PD_DEBOUNCE_CYCLES_DEF = 500_000;
    localparam int unsigned PD_HOLDOFF_CYCLES_DEF  = 5_000_000;
    localparam int unsigned PD_STUCK_CYCLES_DEF    = 200_000_000;
    localparam int unsigned PD_CNT_W               = 28;
    localparam int unsigned PD_DROP_W              = 16;

    typedef enum logic [2:0] {
        PD_IDLE,
        PD_QUAL,
        PD_BLOCKED,
        PD_CLEAR_QUAL,
        PD_HOLDOFF,
        PD_FAULT
    } pd_state_e;

    function automatic logic [PD_DROP_W-1:0] sat_inc_drop(input logic [PD_DROP_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/prize_detector_if.sv
// Sensor-side inputs and scoring outputs of the prize detector.
interface prize_detector_if;
    import clawgame_pkg::*;

    logic                 sensor_raw;
    logic                 game_active;
    logic                 score_increment;
    logic [PD_DROP_W-1:0] drop_count;
    logic                 sensor_fault;

    modport master (
        output sensor_raw,
        output game_active,
        input  score_increment,
        input  drop_count,
        input  sensor_fault
    );

    modport slave (
        input  sensor_raw,
        input  game_active,
        output score_increment,
        output drop_count,
        output sensor_fault
    );

endinterface

// File: rtl/bit_synchronizer.sv
// Two-flop synchronizer for a single asynchronous bit; clears to 0 on reset.
module bit_synchronizer (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/prize_detector.sv
// Debounced chute beam-break detector: qualifies drops, scores them while a
// round is active, and flags a beam that stays blocked too long.
module prize_detector
    import clawgame_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = PD_DEBOUNCE_CYCLES_DEF,
    parameter int unsigned HOLDOFF_CYCLES  = PD_HOLDOFF_CYCLES_DEF,
    parameter int unsigned STUCK_CYCLES    = PD_STUCK_CYCLES_DEF
) (
    input  logic            clock,
    input  logic            reset,
    prize_detector_if.slave pd
);

    localparam logic [PD_CNT_W-1:0] DEB_LAST   = PD_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PD_CNT_W-1:0] HOLD_LAST  = PD_CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [PD_CNT_W-1:0] STUCK_LAST = PD_CNT_W'(STUCK_CYCLES - 1);

    logic                 s;
    pd_state_e            state_q, state_d;
    logic [PD_CNT_W-1:0]  cnt_q, cnt_d;
    logic [PD_DROP_W-1:0] drop_q, drop_d;
    logic                 score_q, score_d;
    logic                 qualify;

    bit_synchronizer u_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (pd.sensor_raw),
        .q_o   (s)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= PD_IDLE;
            cnt_q   <= '0;
            drop_q  <= '0;
            score_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            score_q <= score_d;
        end
    end

    // Each timed state leaves as soon as its condition breaks, so the shared
    // counter only ever measures the current uninterrupted run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        unique case (state_q)
            PD_IDLE: begin
                cnt_d = '0;
                if (s) state_d = PD_QUAL;
            end
            PD_QUAL: begin
                if (!s)                   state_d = PD_IDLE;
                else if (cnt_q == DEB_LAST) state_d = PD_BLOCKED;
            end
            PD_BLOCKED: begin
                if (!s)                     state_d = PD_CLEAR_QUAL;
                else if (cnt_q == STUCK_LAST) state_d = PD_FAULT;
            end
            PD_CLEAR_QUAL: begin
                if (s)                    state_d = PD_BLOCKED;
                else if (cnt_q == DEB_LAST) state_d = PD_HOLDOFF;
            end
            PD_HOLDOFF: begin
                if (cnt_q == HOLD_LAST) state_d = PD_IDLE;
            end
            PD_FAULT: begin
                if (s)                    cnt_d   = '0;
                else if (cnt_q == DEB_LAST) state_d = PD_HOLDOFF;
            end
            default: state_d = PD_IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_comb begin
        qualify = (state_q == PD_QUAL) && (state_d == PD_BLOCKED);
        drop_d  = qualify ? sat_inc_drop(drop_q) : drop_q;
        score_d = qualify && pd.game_active;
    end

    assign pd.score_increment = score_q;
    assign pd.drop_count      = drop_q;
    assign pd.sensor_fault    = (state_q == PD_FAULT);

endmodule
